// File: rtl/bat_amateur_mem_dumper_if.sv
// BatAmateur external RAM read port plus the valid/ready word stream produced by the dumper.
// The dumper drives the master side; the RAM and the consumer sit on the slave side.
interface bat_amateur_mem_dumper_if #(
  parameter int ADDRESS_WIDTH = 16
);
  logic                     EXT_RAM_EN;
  logic                     EXT_RAM_RW;
  logic [ADDRESS_WIDTH-1:0] ADDRESS;
  logic [15:0]              DATA;
  logic [15:0]              OUT_DATA;
  logic [ADDRESS_WIDTH-1:0] OUT_ADDR;
  logic                     OUT_VALID;
  logic                     OUT_READY;

  modport master (
    output EXT_RAM_EN, EXT_RAM_RW, ADDRESS, OUT_DATA, OUT_ADDR, OUT_VALID,
    input  DATA, OUT_READY
  );

  modport slave (
    input  EXT_RAM_EN, EXT_RAM_RW, ADDRESS, OUT_DATA, OUT_ADDR, OUT_VALID,
    output DATA, OUT_READY
  );
endinterface

// File: rtl/bat_amateur_mem_dumper.sv
// Reads a range of BatAmateur external RAM while the CPU is halted and streams
// each word, tagged with its address, over a single-entry valid/ready output.
module bat_amateur_mem_dumper #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     HALT,
  input  logic                     START,
  input  logic [ADDRESS_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDRESS_WIDTH-1:0] WORD_COUNT,
  bat_amateur_mem_dumper_if.master bus,
  output logic                     BUSY,
  output logic                     DONE,
  output logic                     ERROR
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HALT = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_PRESENT   = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2:0]               LAT_LAST  = 3'(RD_LATENCY);

  state_t                   state_r;
  logic [ADDRESS_WIDTH-1:0] cur_addr_r;
  logic [ADDRESS_WIDTH-1:0] remaining_r;
  logic [2:0]               lat_cnt_r;
  logic                     ext_ram_en_r;
  logic [ADDRESS_WIDTH-1:0] address_r;
  logic [15:0]              out_data_r;
  logic [ADDRESS_WIDTH-1:0] out_addr_r;
  logic                     out_valid_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     error_r;

  assign bus.EXT_RAM_EN = ext_ram_en_r;
  assign bus.EXT_RAM_RW = 1'b0;
  assign bus.ADDRESS    = address_r;
  assign bus.OUT_DATA   = out_data_r;
  assign bus.OUT_ADDR   = out_addr_r;
  assign bus.OUT_VALID  = out_valid_r;
  assign BUSY           = busy_r;
  assign DONE           = done_r;
  assign ERROR          = error_r;

  // Dump sequencer; DONE/ERROR/EXT_RAM_EN are set on the edge entering the state that shows them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      cur_addr_r   <= ADDR_ZERO;
      remaining_r  <= ADDR_ZERO;
      lat_cnt_r    <= 3'd0;
      ext_ram_en_r <= 1'b0;
      address_r    <= ADDR_ZERO;
      out_data_r   <= 16'h0000;
      out_addr_r   <= ADDR_ZERO;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            cur_addr_r  <= BASE_ADDR;
            remaining_r <= WORD_COUNT;
            busy_r      <= 1'b1;
            if (WORD_COUNT == ADDR_ZERO) begin
              state_r <= ST_FINISH;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_WAIT_HALT;
            end
          end
        end
        ST_WAIT_HALT: begin
          if (HALT) begin
            state_r      <= ST_ISSUE;
            ext_ram_en_r <= 1'b1;
            address_r    <= cur_addr_r;
          end
        end
        ST_ISSUE: begin
          if (!HALT) begin
            state_r      <= ST_FINISH;
            ext_ram_en_r <= 1'b0;
            done_r       <= 1'b1;
            error_r      <= 1'b1;
          end else begin
            state_r   <= ST_WAIT_DATA;
            lat_cnt_r <= 3'd1;
          end
        end
        ST_WAIT_DATA: begin
          // Losing HALT mid-read aborts; the in-flight word is dropped, never presented.
          if (!HALT) begin
            state_r      <= ST_FINISH;
            ext_ram_en_r <= 1'b0;
            done_r       <= 1'b1;
            error_r      <= 1'b1;
          end else if (lat_cnt_r == LAT_LAST) begin
            out_data_r   <= bus.DATA;
            out_addr_r   <= cur_addr_r;
            out_valid_r  <= 1'b1;
            ext_ram_en_r <= 1'b0;
            state_r      <= ST_PRESENT;
          end else begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        ST_PRESENT: begin
          if (bus.OUT_READY) begin
            out_valid_r <= 1'b0;
            remaining_r <= remaining_r - ADDR_ONE;
            cur_addr_r  <= cur_addr_r + ADDR_ONE;
            if (remaining_r == ADDR_ONE) begin
              state_r <= ST_FINISH;
              done_r  <= 1'b1;
            end else if (HALT) begin
              state_r      <= ST_ISSUE;
              ext_ram_en_r <= 1'b1;
              address_r    <= cur_addr_r + ADDR_ONE;
            end else begin
              state_r <= ST_WAIT_HALT;
            end
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          ext_ram_en_r <= 1'b0;
          out_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/bat_amateur_mem_dumper.md
Name: bat_amateur_mem_dumper

Overview:
Bus reader for the BatAmateur external RAM port. The stimulus side writes programs into RAM over this port. This block is the other direction: once the CPU asserts HALT, it reads a range of RAM back through the same port and streams each word out on a valid/ready interface. The bench uses it to check results, and hardware can use it for debug readout.

Parameters:
ADDRESS_WIDTH, 16, width of ADDRESS, BASE_ADDR, WORD_COUNT, OUT_ADDR
RD_LATENCY, 1, cycles from address presented to DATA valid on the bus (legal range 1..4)

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
HALT  in  1  CPU halted; external RAM port may be used only while high
START  in  1  single-cycle request to begin a dump
BASE_ADDR  in  ADDRESS_WIDTH  first address to read, latched on accepted START
WORD_COUNT  in  ADDRESS_WIDTH  number of words to read, latched on accepted START; 0 means none
EXT_RAM_EN  out  1  requests the external RAM port
EXT_RAM_RW  out  1  RAM direction; tied 0 (read), never writes
ADDRESS  out  ADDRESS_WIDTH  RAM address, valid while EXT_RAM_EN=1
DATA  in  16  shared data bus, sampled only; this block never drives it
OUT_DATA  out  16  word read from RAM
OUT_ADDR  out  ADDRESS_WIDTH  address that OUT_DATA came from
OUT_VALID  out  1  OUT_DATA/OUT_ADDR valid
OUT_READY  in  1  consumer accepts the word when high together with OUT_VALID
BUSY  out  1  dump in progress (any state other than IDLE)
DONE  out  1  one-cycle pulse when a dump ends, normally or aborted
ERROR  out  1  one-cycle pulse, coincident with DONE, when a dump is aborted

Behaviour:
- Reset values: EXT_RAM_EN=0, EXT_RAM_RW=0, ADDRESS=0, OUT_DATA=0, OUT_ADDR=0, OUT_VALID=0, BUSY=0, DONE=0, ERROR=0. FSM state is IDLE.
- States: IDLE, WAIT_HALT, ISSUE, WAIT_DATA, PRESENT, FINISH.
- IDLE:
  - START=1 latches cur_addr=BASE_ADDR and remaining=WORD_COUNT.
  - If WORD_COUNT=0, go to FINISH; no bus cycle is issued.
  - Otherwise go to WAIT_HALT.
  - START is ignored in every state except IDLE.
- WAIT_HALT: stay while HALT=0; go to ISSUE when HALT=1. Waiting here is a pause, not an error.
- ISSUE (1 cycle):
  - EXT_RAM_EN=1, ADDRESS=cur_addr, then go to WAIT_DATA.
  - Entering ISSUE with HALT=0 diverts to WAIT_HALT instead.
- WAIT_DATA:
  - EXT_RAM_EN and ADDRESS are held, with a latency counter.
  - On the edge ending the RD_LATENCY-th cycle after ISSUE: OUT_DATA<=DATA, OUT_ADDR<=cur_addr, OUT_VALID<=1, EXT_RAM_EN<=0, go to PRESENT.
  - With RD_LATENCY=1, DATA is sampled on the edge ending the first WAIT_DATA cycle.
- PRESENT:
  - OUT_DATA, OUT_ADDR and OUT_VALID stay stable until OUT_READY=1. Only one word is outstanding; there is no further buffering.
  - On the accept edge: OUT_VALID<=0, remaining<=remaining-1, cur_addr<=cur_addr+1 (mod 2^ADDRESS_WIDTH).
  - Then go to FINISH if remaining was 1, else to ISSUE.
- FINISH (1 cycle): DONE=1, then back to IDLE.
- Throughput: at best one word per RD_LATENCY+2 cycles.
- EXT_RAM_EN: asserted only in ISSUE and WAIT_DATA, and only while HALT=1. It is never high in IDLE, WAIT_HALT, PRESENT or FINISH.
- Abort: HALT falls while in ISSUE or WAIT_DATA.
  - Next edge: EXT_RAM_EN<=0, read discarded (OUT_VALID stays 0), go to FINISH.
  - In FINISH: DONE=1 and ERROR=1 in the same cycle.
- HALT falling in PRESENT does not abort. The held word still completes its handshake; the following ISSUE diverts to WAIT_HALT.
- Address wrap: cur_addr past 2^ADDRESS_WIDTH-1 wraps to 0. WORD_COUNT=2^ADDRESS_WIDTH-1 is legal.
- Reset mid-dump: RST overrides everything on the next edge. All outputs take their reset values, including EXT_RAM_EN=0, with no DONE pulse.
- BUSY=1 in every state except IDLE, including FINISH.

Test Plan:
- Basic dump: RAM[0x0010..0x0013]=0xA001..0xA004, HALT=1, START with BASE=0x0010, COUNT=4, OUT_READY=1 -> four words 0xA001..0xA004 with OUT_ADDR 0x0010..0x0013, words 3 cycles apart; DONE pulses once; ERROR=0; EXT_RAM_RW=0 throughout.
- Backpressure: same setup, OUT_READY=0 for 5 cycles on word 2 -> OUT_DATA/OUT_ADDR held stable with OUT_VALID=1; EXT_RAM_EN=0 during the stall; all 4 words delivered in order, no duplicates or drops.
- Zero count and ignored START: START with COUNT=0 -> DONE two cycles later, EXT_RAM_EN never asserted. A second START during a 4-word dump -> ignored; exactly 4 words delivered.
- HALT gating and abort:
  - START with HALT=0 -> BUSY=1, EXT_RAM_EN=0 until HALT rises; dump then proceeds normally.
  - HALT dropped in WAIT_DATA of word 2 -> EXT_RAM_EN=0 next cycle; DONE and ERROR pulse together; only word 1 was delivered.
- Wrap and latency: RD_LATENCY=2, BASE=0xFFFE, COUNT=4 -> OUT_ADDR sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001; DATA sampled 2 cycles after ISSUE; words 4 cycles apart.
- Reset mid-dump: RST asserted in PRESENT -> next cycle all outputs at reset values, no DONE; a new START afterwards runs a clean dump.
